// File: rtl/eight_count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : eight_count_monitor
// Description : Watches an 8-bit up-counter, locks after a run of good
//               increments, and counts mismatches and 255->0 wraps once locked.
// Revision    : 1.0 - initial release
// ============================================================================
module eight_count_monitor #(
    parameter int LOCK_LEN  = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic       trigger,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] y_in,
    input  logic       clear_err,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_count,
    output logic [7:0] wrap_count,
    output logic [7:0] last_y,
    output logic [1:0] state
);

    localparam logic [1:0] c_IDLE    = 2'b00;
    localparam logic [1:0] c_ACQUIRE = 2'b01;
    localparam logic [1:0] c_LOCKED  = 2'b10;

    localparam logic [3:0] c_LOCK_LEN  = 4'(LOCK_LEN);
    localparam logic [3:0] c_ERR_LIMIT = 4'(ERR_LIMIT);

    logic [1:0] r_state;
    logic       r_locked;
    logic       r_err_pulse;
    logic [7:0] r_err_count;
    logic [7:0] r_wrap_count;
    logic [7:0] r_prev_y;
    logic [3:0] r_run_len;
    logic [3:0] r_miss_cnt;

    logic [7:0] w_expect_y;
    logic       w_good;
    logic       w_wrap;
    logic [3:0] w_run_inc;
    logic [3:0] w_miss_inc;
    logic [7:0] w_err_inc;

    // Modular increment makes 255->0 a good step naturally.
    assign w_expect_y = r_prev_y + 8'd1;
    assign w_good     = (y_in == w_expect_y);
    assign w_wrap     = (r_prev_y == 8'hFF) && (y_in == 8'h00);
    assign w_run_inc  = r_run_len + 4'd1;
    assign w_miss_inc = r_miss_cnt + 4'd1;
    assign w_err_inc  = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

    always_ff @(posedge trigger) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_count  <= 8'd0;
            r_wrap_count <= 8'd0;
            r_prev_y     <= 8'd0;
            r_run_len    <= 4'd0;
            r_miss_cnt   <= 4'd0;
        end else if (!enable) begin
            r_state     <= c_IDLE;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            if (clear_err) begin
                r_err_count <= 8'd0;
            end
        end else begin
            r_prev_y    <= y_in;
            r_err_pulse <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_state    <= c_ACQUIRE;
                    r_locked   <= 1'b0;
                    r_run_len  <= 4'd0;
                    r_miss_cnt <= 4'd0;
                    if (clear_err) begin
                        r_err_count <= 8'd0;
                    end
                end
                c_ACQUIRE: begin
                    r_miss_cnt <= 4'd0;
                    if (clear_err) begin
                        r_err_count <= 8'd0;
                    end
                    if (w_good) begin
                        r_run_len <= w_run_inc;
                        if (w_run_inc >= c_LOCK_LEN) begin
                            r_state   <= c_LOCKED;
                            r_locked  <= 1'b1;
                            r_run_len <= c_LOCK_LEN;
                        end
                    end else begin
                        r_run_len <= 4'd0;
                    end
                end
                c_LOCKED: begin
                    if (w_good) begin
                        r_miss_cnt <= 4'd0;
                        if (w_wrap) begin
                            r_wrap_count <= r_wrap_count + 8'd1;
                        end
                        if (clear_err) begin
                            r_err_count <= 8'd0;
                        end
                    end else begin
                        r_err_pulse <= 1'b1;
                        // A clear on the same edge wins over the increment.
                        r_err_count <= clear_err ? 8'd0 : w_err_inc;
                        if (w_miss_inc >= c_ERR_LIMIT) begin
                            r_state    <= c_ACQUIRE;
                            r_locked   <= 1'b0;
                            r_run_len  <= 4'd0;
                            r_miss_cnt <= 4'd0;
                        end else begin
                            r_miss_cnt <= w_miss_inc;
                        end
                    end
                end
                default: begin
                    r_state  <= c_IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign err_count  = r_err_count;
    assign wrap_count = r_wrap_count;
    assign last_y     = r_prev_y;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_eight_count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_eight_count_monitor
// Description : Directed self-checking bench for eight_count_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eight_count_monitor;

    logic       trigger;
    logic       rst_n;
    logic       enable;
    logic [7:0] y_in;
    logic       clear_err;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [7:0] wrap_count;
    logic [7:0] last_y;
    logic [1:0] state;

    int n_tests  = 0;
    int n_failed = 0;
    logic [7:0] cy;

    eight_count_monitor #(.LOCK_LEN(4), .ERR_LIMIT(3)) dut (
        .trigger    (trigger),
        .rst_n      (rst_n),
        .enable     (enable),
        .y_in       (y_in),
        .clear_err  (clear_err),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .wrap_count (wrap_count),
        .last_y     (last_y),
        .state      (state)
    );

    initial trigger = 1'b0;
    always #5 trigger = ~trigger;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [7:0] y, input logic en, input logic clr);
        @(negedge trigger);
        y_in      = y;
        enable    = en;
        clear_err = clr;
        @(posedge trigger);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; clear_err = 1'b1; y_in = 8'd77;
        tick(8'd77, 1'b1, 1'b1);
        tick(8'd78, 1'b1, 1'b1);
        check("rst_state", state, 0);
        check("rst_locked", locked, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_err", err_count, 0);
        check("rst_wrap", wrap_count, 0);
        check("rst_last_y", last_y, 0);

        // Acquisition: 10 loads in IDLE, 11..13 build the run, 14 locks.
        rst_n = 1'b1;
        tick(8'd10, 1'b1, 1'b0);
        check("acq10_state", state, 1);
        tick(8'd11, 1'b1, 1'b0);
        tick(8'd12, 1'b1, 1'b0);
        tick(8'd13, 1'b1, 1'b0);
        check("acq13_state", state, 1);
        check("acq13_locked", locked, 0);
        tick(8'd14, 1'b1, 1'b0);
        check("lock14_state", state, 2);
        check("lock14_locked", locked, 1);
        check("lock14_err", err_count, 0);
        check("lock14_last_y", last_y, 14);

        // Walk up to the wrap point.
        for (int v = 15; v <= 252; v++) tick(8'(v), 1'b1, 1'b0);
        tick(8'd253, 1'b1, 1'b0);
        tick(8'd254, 1'b1, 1'b0);
        tick(8'd255, 1'b1, 1'b0);
        check("pre_wrap", wrap_count, 0);
        tick(8'd0, 1'b1, 1'b0);
        check("wrap0_count", wrap_count, 1);
        check("wrap0_pulse", err_pulse, 0);
        tick(8'd1, 1'b1, 1'b0);
        check("wrap1_count", wrap_count, 1);
        check("wrap1_locked", locked, 1);
        check("wrap_err", err_count, 0);

        // Single mismatch then resync.
        for (int v = 2; v <= 20; v++) tick(8'(v), 1'b1, 1'b0);
        tick(8'd25, 1'b1, 1'b0);
        check("bad25_pulse", err_pulse, 1);
        check("bad25_err", err_count, 1);
        check("bad25_locked", locked, 1);
        tick(8'd26, 1'b1, 1'b0);
        check("good26_pulse", err_pulse, 0);
        check("good26_locked", locked, 1);
        // Two more misses must not unlock if 26 cleared the miss counter.
        tick(8'd40, 1'b1, 1'b0);
        tick(8'd50, 1'b1, 1'b0);
        check("two_miss_locked", locked, 1);
        check("two_miss_err", err_count, 3);
        tick(8'd51, 1'b1, 1'b0);

        // Three consecutive misses drop lock on the third.
        tick(8'd40, 1'b1, 1'b0);
        tick(8'd50, 1'b1, 1'b0);
        check("miss50_locked", locked, 1);
        tick(8'd60, 1'b1, 1'b0);
        check("miss60_state", state, 1);
        check("miss60_locked", locked, 0);
        check("miss60_err", err_count, 6);
        check("miss60_pulse", err_pulse, 1);
        tick(8'd99, 1'b1, 1'b0);
        check("acq_no_pulse", err_pulse, 0);
        check("acq_no_err", err_count, 6);

        // Relock from 99, then drive errors up to saturation.
        for (int v = 100; v <= 103; v++) tick(8'(v), 1'b1, 1'b0);
        check("relock", locked, 1);
        cy = 8'd103;
        for (int k = 0; k < 249; k++) begin
            cy = cy + 8'd5; tick(cy, 1'b1, 1'b0);
            cy = cy + 8'd1; tick(cy, 1'b1, 1'b0);
        end
        check("sat_reach", err_count, 255);
        cy = cy + 8'd5; tick(cy, 1'b1, 1'b0);
        check("sat_hold", err_count, 255);
        check("sat_pulse", err_pulse, 1);
        check("sat_locked", locked, 1);

        // Disable while locked: return to IDLE, hold counters.
        tick(8'd3, 1'b0, 1'b0);
        check("dis_state", state, 0);
        check("dis_locked", locked, 0);
        check("dis_err", err_count, 255);
        check("dis_last_y", last_y, cy);
        check("dis_wrap", wrap_count, 1);

        // Re-enable, relock, then clear_err with a mismatch.
        for (int v = 30; v <= 34; v++) tick(8'(v), 1'b1, 1'b0);
        check("relock2", locked, 1);
        tick(8'd90, 1'b1, 1'b1);
        check("clr_err", err_count, 0);
        check("clr_pulse", err_pulse, 1);
        cy = 8'd91; tick(cy, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cy = cy + 8'd5; tick(cy, 1'b1, 1'b0);
            cy = cy + 8'd1; tick(cy, 1'b1, 1'b0);
        end
        check("err5", err_count, 5);
        check("err5_locked", locked, 1);

        // Reset mid-LOCKED with a mismatch presented: no partial update.
        rst_n = 1'b0;
        tick(cy + 8'd7, 1'b1, 1'b1);
        check("rst2_state", state, 0);
        check("rst2_locked", locked, 0);
        check("rst2_pulse", err_pulse, 0);
        check("rst2_err", err_count, 0);
        check("rst2_wrap", wrap_count, 0);
        check("rst2_last_y", last_y, 0);

        rst_n = 1'b1;
        tick(8'd99, 1'b0, 1'b0);
        tick(8'd100, 1'b0, 1'b0);
        check("idle_state", state, 0);
        check("idle_last_y", last_y, 0);
        check("idle_locked", locked, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eight_count_monitor.md
EIGHT_COUNT_MONITOR -- requirements
Module: eight_count_monitor

Interface
REQ-001 Parameter LOCK_LEN, default 4: number of consecutive good increments (range 1..15) needed to lock.
REQ-002 Parameter ERR_LIMIT, default 3: number of consecutive mismatches (range 1..15) that drops lock.
REQ-003 trigger  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 enable  in  1  monitor enable, sampled each edge.
REQ-006 y_in  in  8  count value from the 8-bit counter under observation.
REQ-007 clear_err  in  1  synchronous clear of err_count.
REQ-008 locked  out  1  high while state = LOCKED.
REQ-009 err_pulse  out  1  one-cycle pulse, high for each mismatch detected in LOCKED.
REQ-010 err_count  out  8  total mismatches; saturates at 255.
REQ-011 wrap_count  out  8  number of 255->0 wraps seen while LOCKED; wraps modulo 256.
REQ-012 last_y  out  8  most recent sampled y_in (prev_y).
REQ-013 state  out  2  00 IDLE, 01 ACQUIRE, 10 LOCKED; 11 unused.

Function
REQ-014 All outputs SHALL be registered; responses appear on the edge that samples the triggering y_in (latency 1 edge).
REQ-015 "Good" SHALL mean y_in == (prev_y + 1) mod 256, using 8-bit modular arithmetic, so 255->0 is good.
REQ-016 IDLE: with enable=1, load prev_y=y_in, clear run_len and miss_cnt, and go to ACQUIRE; with enable=0, stay in IDLE.
REQ-017 ACQUIRE, good sample: run_len++; when run_len reaches LOCK_LEN, go to LOCKED, with locked=1 on that same edge.
REQ-018 ACQUIRE, bad sample: run_len=0 and stay; no err_pulse and no err_count change.
REQ-019 LOCKED, good sample: miss_cnt=0 and err_pulse=0; if prev_y==255 and y_in==0, wrap_count++.
REQ-020 LOCKED, bad sample: err_pulse=1, err_count++ (saturating at 255), miss_cnt++.
REQ-021 LOCKED, when miss_cnt reaches ERR_LIMIT: go to ACQUIRE with run_len=0 and locked=0 on that same edge.
REQ-022 prev_y SHALL load y_in on every edge with enable=1 in all states; bad samples also load it, so the monitor resynchronises to the new value.
REQ-023 enable=0 in any state: go to IDLE next edge; set locked=0 and err_pulse=0; hold err_count, wrap_count and last_y.
REQ-024 clear_err=1: err_count=0 on that edge and takes priority over a simultaneous mismatch; err_pulse still fires.
REQ-025 Internal counters: run_len and miss_cnt are 4 bits and SHALL never exceed their limits.
REQ-026 State 11 SHALL never be entered; if it is reached, the next edge SHALL go to IDLE.

Reset
REQ-027 rst_n=0 at an edge SHALL set: state=IDLE, locked=0, err_pulse=0, err_count=0, wrap_count=0, last_y=0, run_len=0, miss_cnt=0.
REQ-028 Reset SHALL override enable and clear_err.
REQ-029 Reset asserted mid-LOCKED SHALL abort on the same edge; no partial error or wrap update.

Verification
REQ-030 Reset, then enable=1, y_in=10,11,12,13,14 on successive edges -> state=ACQUIRE through 13; locked=1 on the edge sampling 14; err_count=0.
REQ-031 Locked, y_in 253,254,255,0,1 -> wrap_count increments by 1 exactly on the edge sampling 0; no err_pulse.
REQ-032 Locked, prev_y=20, y_in=25 then 26 -> one err_pulse and err_count=1; on 26 (good vs 25), miss_cnt=0 and still locked.
REQ-033 Locked, three bad samples 40,50,60 (ERR_LIMIT=3) -> err_count+3; locked=0 and state=ACQUIRE on the edge sampling 60.
REQ-034 err_count=255 plus a further mismatch -> stays 255; clear_err together with a mismatch -> err_count=0 and err_pulse=1.
REQ-035 Locked with err_count=5, then rst_n=0 for one edge -> all outputs at reset values; then enable=0 -> state held at IDLE with y_in ignored.
